// File: rtl/mem_rsp_pkg.sv
// rtl/mem_rsp_pkg.sv - shared widths and FSM state type for mem_responder
package mem_rsp_pkg;

  localparam int WORD_W = 32;
  localparam int LEN_W  = 3;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RD,
    WR,
    ACK
  } rsp_state_t;

endpackage

// File: rtl/mem_rsp_ram.sv
// rtl/mem_rsp_ram.sv - single-port word array, synchronous read with one-cycle latency
module mem_rsp_ram
  import mem_rsp_pkg::*;
#(
  parameter int WORDS = 4096,
  parameter int AW    = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [WORDS];

  // Write when enabled; the read register always samples the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - burst memory responder; MEM_RANGE_CHECK_EN enables out-of-range burst errors
module mem_responder
  import mem_rsp_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 4,
  parameter int MAX_LEN   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [31:0]       req_adr,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              wd_valid,
  output logic              wd_ready,
  input  logic [WORD_W-1:0] wd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [WORD_W-1:0] rd_data,
  output logic              rd_last,
  output logic              wr_ack,
  output logic              rsp_err
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int CW = $clog2(MAX_LEN + 1);

  rsp_state_t        state;
  logic [AW-1:0]     idx;
  logic [AW-1:0]     req_idx;
  logic [AW-1:0]     ram_addr;
  logic [CW-1:0]     left;
  logic [3:0]        wcnt;
  logic              wr_q;
  logic              err_q;
  logic              range_err;
  logic              ram_we;
  logic              accept;
  logic [WORD_W-1:0] ram_q;
  logic              unused_adr;

  assign accept     = req_valid && req_ready;
  assign req_idx    = req_adr[AW+1:2];
  assign unused_adr = ^{req_adr[31:AW+2], req_adr[1:0]};

`ifdef MEM_RANGE_CHECK_EN
  logic [30:0] end_idx;
  assign end_idx   = {1'b0, req_adr[31:2]} + 31'(req_len);
  assign range_err = end_idx > 31'(MEM_WORDS - 1);
`else
  assign range_err = 1'b0;
`endif

  // Erroring bursts still consume their write beats but never touch the array.
  assign ram_we  = (state == WR) && wd_valid && !err_q;
  assign rd_data = (rd_valid && !rsp_err) ? ram_q : '0;

  // Address the array one cycle ahead: the request word in IDLE, the next word when a read beat is taken.
  always_comb begin
    ram_addr = idx;
    if (state == IDLE) begin
      ram_addr = req_idx;
    end else if (state == RD && rd_ready) begin
      ram_addr = idx + AW'(1);
    end
  end

  mem_rsp_ram #(
    .WORDS(MEM_WORDS),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .addr (ram_addr),
    .wdata(wd_data),
    .rdata(ram_q)
  );

  // Request FSM with registered handshake outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      wd_ready  <= 1'b0;
      rd_valid  <= 1'b0;
      rd_last   <= 1'b0;
      wr_ack    <= 1'b0;
      rsp_err   <= 1'b0;
      idx       <= '0;
      left      <= '0;
      wcnt      <= '0;
      wr_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            req_ready <= 1'b0;
            wr_q      <= req_wr;
            idx       <= req_idx;
            left      <= CW'(req_len) + CW'(1);
            err_q     <= range_err;
            if (LATENCY == 0) begin
              state    <= req_wr ? WR : RD;
              wd_ready <= req_wr;
              rd_valid <= !req_wr;
              rd_last  <= !req_wr && (req_len == '0);
              rsp_err  <= !req_wr && range_err;
            end else begin
              state <= WAIT;
              wcnt  <= 4'(LATENCY - 1);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (wcnt == '0) begin
            state    <= wr_q ? WR : RD;
            wd_ready <= wr_q;
            rd_valid <= !wr_q;
            rd_last  <= !wr_q && (left == CW'(1));
            rsp_err  <= !wr_q && err_q;
          end else begin
            wcnt <= wcnt - 4'd1;
          end
        end
        RD: begin
          if (rd_ready) begin
            if (left == CW'(1)) begin
              state     <= IDLE;
              rd_valid  <= 1'b0;
              rd_last   <= 1'b0;
              rsp_err   <= 1'b0;
              req_ready <= 1'b1;
            end else begin
              left    <= left - CW'(1);
              idx     <= idx + AW'(1);
              rd_last <= (left == CW'(2));
            end
          end
        end
        WR: begin
          if (wd_valid) begin
            if (left == CW'(1)) begin
              state    <= ACK;
              wd_ready <= 1'b0;
              wr_ack   <= 1'b1;
              rsp_err  <= err_q;
            end else begin
              left <= left - CW'(1);
              idx  <= idx + AW'(1);
            end
          end
        end
        ACK: begin
          state     <= IDLE;
          wr_ack    <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          wd_ready  <= 1'b0;
          rd_valid  <= 1'b0;
          rd_last   <= 1'b0;
          wr_ack    <= 1'b0;
          rsp_err   <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - directed self-checking bench for mem_responder (MEM_RANGE_CHECK_EN aware)
module tb_mem_responder;

  localparam int LAT = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_wr, wd_valid, wd_ready;
  logic        rd_valid, rd_ready, rd_last, wr_ack, rsp_err;
  logic [31:0] req_adr, wd_data, rd_data;
  logic [2:0]  req_len;

  logic        b_req_valid, b_req_ready, b_wd_ready, b_rd_valid, b_rd_ready;
  logic        b_rd_last, b_wr_ack, b_rsp_err;
  logic [31:0] b_rd_data;

  mem_responder #(.MEM_WORDS(4096), .LATENCY(LAT), .MAX_LEN(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_adr(req_adr), .req_len(req_len),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .wr_ack(wr_ack), .rsp_err(rsp_err)
  );

  mem_responder #(.MEM_WORDS(4096), .LATENCY(0), .MAX_LEN(8)) dut_l0 (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_wr(1'b0),
    .req_adr(32'h0), .req_len(3'd0),
    .wd_valid(1'b0), .wd_ready(b_wd_ready), .wd_data(32'h0),
    .rd_valid(b_rd_valid), .rd_ready(b_rd_ready), .rd_data(b_rd_data), .rd_last(b_rd_last),
    .wr_ack(b_wr_ack), .rsp_err(b_rsp_err)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] wdat [8];
  logic [31:0] edat [8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] adr, input logic [2:0] len, input logic [15:0] vpat);
    int n, i, g, acks;
    logic take;
    req_valid = 1'b1; req_wr = 1'b1; req_adr = adr; req_len = len;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    check("wr_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    i = 0; g = 0; n = 0; acks = 0;
    while (i <= int'(len) && n < 100) begin
      if (wd_ready) begin
        wd_valid = vpat[g % 16];
        g++;
      end else begin
        wd_valid = 1'b0;
      end
      wd_data = wdat[i];
      take = wd_valid && wd_ready;
      if (wr_ack) acks++;
      step();
      if (take) i++;
      n++;
    end
    wd_valid = 1'b0;
    check("wr_beats", i, int'(len) + 1);
    check("wr_early_ack", acks, 0);
    check("wr_ack", wr_ack, 1);
    check("wr_err", rsp_err, 0);
    check("wr_wd_ready_off", wd_ready, 0);
    step();
    check("wr_ack_pulse", wr_ack, 0);
    check("wr_idle_ready", req_ready, 1);
  endtask

  task automatic do_read(input logic [31:0] adr, input logic [2:0] len, input logic [15:0] rpat,
                         input logic exp_err);
    int n, i, g, k;
    logic stalled;
    logic [31:0] held;
    req_valid = 1'b1; req_wr = 1'b0; req_adr = adr; req_len = len; rd_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    check("rd_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    k = 1;
    while (!rd_valid && k < 50) begin step(); k++; end
    check("rd_latency", k, LAT + 1);
    i = 0; g = 0; n = 0; stalled = 1'b0; held = '0;
    while (i <= int'(len) && n < 100) begin
      check("rd_valid", rd_valid, 1);
      if (stalled) check("rd_stable", rd_data, held);
      rd_ready = rpat[g % 16];
      g++;
      if (rd_ready) begin
        check("rd_data", rd_data, exp_err ? 32'h0 : edat[i]);
        check("rd_last", rd_last, i == int'(len));
        check("rd_err", rsp_err, exp_err);
        i++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
        held = rd_data;
      end
      step();
      n++;
    end
    rd_ready = 1'b0;
    check("rd_beats", i, int'(len) + 1);
    check("rd_done_valid", rd_valid, 0);
    check("rd_done_ready", req_ready, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b0;
    req_valid = 1'b0; req_wr = 1'b0; req_adr = '0; req_len = '0;
    wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
    b_req_valid = 1'b0; b_rd_ready = 1'b0;
    step(); step();

    // reset state
    check("rst_req_ready", req_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_wd_ready", wd_ready, 0);
    check("rst_wr_ack", wr_ack, 0);
    check("rst_rsp_err", rsp_err, 0);
    rst = 1'b1;
    step();
    check("rel_req_ready", req_ready, 1);

    // write 4 words then read them back
    wdat[0] = 32'h11; wdat[1] = 32'h22; wdat[2] = 32'h33; wdat[3] = 32'h44;
    do_write(32'h100, 3'd3, 16'hFFFF);
    for (int i = 0; i < 4; i++) edat[i] = wdat[i];
    do_read(32'h100, 3'd3, 16'hFFFF, 1'b0);

    // 8-word burst, read with rd_ready toggling 1,0,1,0
    for (int i = 0; i < 8; i++) wdat[i] = 32'hA0 + i;
    do_write(32'h200, 3'd7, 16'hFFFF);
    for (int i = 0; i < 8; i++) edat[i] = 32'hA0 + i;
    do_read(32'h200, 3'd7, 16'h5555, 1'b0);

    // gapped write of 2 words (wd_valid 1,0,0,1); third word must be untouched
    wdat[0] = 32'hB0; wdat[1] = 32'hB1;
    do_write(32'h200, 3'd1, 16'hFFF9);
    edat[0] = 32'hB0; edat[1] = 32'hB1; edat[2] = 32'hA2;
    do_read(32'h200, 3'd2, 16'hFFFF, 1'b0);

    // burst crossing the top of the array
    wdat[0] = 32'hC0; wdat[1] = 32'hC1;
    do_write(32'h3FF8, 3'd1, 16'hFFFF);
    wdat[0] = 32'hD0; wdat[1] = 32'hD1;
    do_write(32'h0, 3'd1, 16'hFFFF);
    edat[0] = 32'hC0; edat[1] = 32'hC1; edat[2] = 32'hD0; edat[3] = 32'hD1;
`ifdef MEM_RANGE_CHECK_EN
    do_read(32'h3FF8, 3'd3, 16'hFFFF, 1'b1);
`else
    do_read(32'h3FF8, 3'd3, 16'hFFFF, 1'b0);
`endif

    // LATENCY=0 instance: back-to-back single-word reads alternate IDLE/RD
    b_req_valid = 1'b1; b_rd_ready = 1'b1;
    n = 0;
    while (!b_req_ready && n < 20) begin step(); n++; end
    for (int k = 0; k < 10; k++) begin
      check("l0_req_ready", b_req_ready, (k % 2) == 0);
      check("l0_rd_valid", b_rd_valid, (k % 2) == 1);
      step();
    end
    b_req_valid = 1'b0; b_rd_ready = 1'b0;
    step();

    // reset while a read beat is being held
    req_valid = 1'b1; req_wr = 1'b0; req_adr = 32'h100; req_len = 3'd0; rd_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin step(); n++; end
    step();
    req_valid = 1'b0;
    n = 0;
    while (!rd_valid && n < 50) begin step(); n++; end
    step();
    check("t1_held_valid", rd_valid, 1);
    check("t1_held_data", rd_data, 32'h11);
    check("t1_held_last", rd_last, 1);
    #2 rst = 1'b0;
    #1;
    check("t1_rd_valid", rd_valid, 0);
    check("t1_rd_last", rd_last, 0);
    check("t1_rd_data", rd_data, 0);
    check("t1_req_ready", req_ready, 0);
    check("t1_wr_ack", wr_ack, 0);
    check("t1_rsp_err", rsp_err, 0);
    rst = 1'b1;
    step();
    check("t1_rel_ready", req_ready, 1);
    check("t1_rel_valid", rd_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
